// File: rtl/calib_packet_reader.sv
// Streams a completed calibration bank as a framed byte stream (A5 5A 0C N_hi N_lo payload trailer); CALIB_CRC16_EN swaps the XOR trailer for CRC-16/CCITT-FALSE.
// Latency: first header byte valid 1 clock after i_calib_make; payload one byte per RD_LAT+2 clocks.
// Backpressure: o_tx_* held stable until accepted; make pulses arriving while busy are dropped and counted.
module calib_packet_reader #(
    parameter int          RD_LAT     = 2,
    parameter int          MAX_POINTS = 128,
    parameter logic [7:0]  HDR0       = 8'hA5,
    parameter logic [7:0]  HDR1       = 8'h5A,
    parameter logic [7:0]  CMD_ID     = 8'h0C
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_calib_make,
    input  logic        i_calib_pingpang,
    input  logic [15:0] i_calib_points,
    output logic        o_calib_rdbank,
    output logic [9:0]  o_calib_rdaddr,
    input  logic [7:0]  i_calib_rddata,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_sof,
    output logic        o_tx_eof,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_RD_ISSUE, S_RD_WAIT, S_DATA, S_CSUM, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        bank_q, bank_d;
    logic [15:0] n_q, n_d;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  last_q, last_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [2:0]  wait_q, wait_d;
    logic [7:0]  data_q, data_d;
    logic        vld_q, vld_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [7:0]  drop_q, drop_d;
    logic        go_trl;
    logic        accept;
    logic [15:0] n_clamp;

`ifdef CALIB_CRC16_EN
    logic [15:0] crc_q, crc_d, crc_nxt;
    logic        trl_q, trl_d;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    assign crc_nxt = crc_upd(crc_q, data_q);
`else
    logic [7:0]  csum_q, csum_d, csum_nxt;
    assign csum_nxt = csum_q ^ data_q;
`endif

    assign accept  = vld_q & i_tx_ready;
    assign n_clamp = (i_calib_points > 16'(MAX_POINTS)) ? 16'(MAX_POINTS) : i_calib_points;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] n);
        case (idx)
            3'd0:    return HDR0;
            3'd1:    return HDR1;
            3'd2:    return CMD_ID;
            3'd3:    return n[15:8];
            default: return n[7:0];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        n_d       = n_q;
        addr_d    = addr_q;
        last_d    = last_q;
        hdr_idx_d = hdr_idx_q;
        wait_d    = wait_q;
        data_d    = data_q;
        vld_d     = vld_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        drop_d    = drop_q;
        go_trl    = 1'b0;
`ifdef CALIB_CRC16_EN
        crc_d     = crc_q;
        trl_d     = trl_q;
`else
        csum_d    = csum_q;
`endif

        if (i_calib_make && state_q != S_IDLE && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;

        case (state_q)
            S_IDLE: if (i_calib_make) begin
                bank_d    = ~i_calib_pingpang;
                n_d       = n_clamp;
                // 8N-1 wraps to 1023 for N=128; unused when N=0
                last_d    = 10'({n_clamp[6:0], 3'b000} - 10'd1);
                hdr_idx_d = 3'd0;
                data_d    = HDR0;
                vld_d     = 1'b1;
                sof_d     = 1'b1;
                eof_d     = 1'b0;
`ifdef CALIB_CRC16_EN
                crc_d     = 16'hFFFF;
                trl_d     = 1'b0;
`else
                csum_d    = 8'h00;
`endif
                state_d   = S_HDR;
            end
            S_HDR: if (accept) begin
                sof_d = 1'b0;
                if (hdr_idx_q >= 3'd2) begin
`ifdef CALIB_CRC16_EN
                    crc_d = crc_nxt;
`else
                    csum_d = csum_nxt;
`endif
                end
                if (hdr_idx_q == 3'd4) begin
                    if (n_q == 16'd0) begin
                        go_trl = 1'b1;
                    end else begin
                        vld_d   = 1'b0;
                        addr_d  = 10'd0;
                        state_d = S_RD_ISSUE;
                    end
                end else begin
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    data_d    = hdr_byte(hdr_idx_q + 3'd1, n_q);
                end
            end
            S_RD_ISSUE: begin
                wait_d  = 3'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == 3'(RD_LAT - 1)) begin
                    data_d  = i_calib_rddata;
                    vld_d   = 1'b1;
                    state_d = S_DATA;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_DATA: if (accept) begin
`ifdef CALIB_CRC16_EN
                crc_d = crc_nxt;
`else
                csum_d = csum_nxt;
`endif
                if (addr_q == last_q) begin
                    go_trl = 1'b1;
                end else begin
                    addr_d  = addr_q + 10'd1;
                    vld_d   = 1'b0;
                    state_d = S_RD_ISSUE;
                end
            end
            S_CSUM: if (accept) begin
`ifdef CALIB_CRC16_EN
                if (!trl_q) begin
                    trl_d  = 1'b1;
                    data_d = crc_q[7:0];
                    eof_d  = 1'b1;
                end else begin
                    vld_d   = 1'b0;
                    eof_d   = 1'b0;
                    state_d = S_DONE;
                end
`else
                vld_d   = 1'b0;
                eof_d   = 1'b0;
                state_d = S_DONE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Trailer folds in the byte being accepted this cycle
        if (go_trl) begin
            vld_d   = 1'b1;
            state_d = S_CSUM;
`ifdef CALIB_CRC16_EN
            data_d  = crc_nxt[15:8];
            eof_d   = 1'b0;
`else
            data_d  = csum_nxt;
            eof_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            bank_q    <= 1'b0;
            n_q       <= 16'd0;
            addr_q    <= 10'd0;
            last_q    <= 10'd0;
            hdr_idx_q <= 3'd0;
            wait_q    <= 3'd0;
            data_q    <= 8'd0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            drop_q    <= 8'd0;
`ifdef CALIB_CRC16_EN
            crc_q     <= 16'hFFFF;
            trl_q     <= 1'b0;
`else
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            n_q       <= n_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            hdr_idx_q <= hdr_idx_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            drop_q    <= drop_d;
`ifdef CALIB_CRC16_EN
            crc_q     <= crc_d;
            trl_q     <= trl_d;
`else
            csum_q    <= csum_d;
`endif
        end
    end

    assign o_calib_rdbank = bank_q;
    assign o_calib_rdaddr = addr_q;
    assign o_tx_valid     = vld_q;
    assign o_tx_data      = data_q;
    assign o_tx_sof       = sof_q;
    assign o_tx_eof       = eof_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_frame_done   = (state_q == S_DONE);
    assign o_drop_cnt     = drop_q;

endmodule

// File: doc/calib_packet_reader.md
Name: calib_packet_reader

Overview:
- Read side of the calibration ping-pong buffer.
- On each completed calibration batch, reads the finished bank (8 bytes per point: rise, fall, dist, rssi, each MSB first) and streams it as a framed byte stream to the W5500 transmit path.
- Frame: header, point count, payload, checksum.
- Sits between the calibration buffer RAM read port and the Ethernet send arbiter.

Parameters:
- RD_LAT, 2, buffer RAM read latency in clocks, from address to data valid (1..4).
- MAX_POINTS, 128, clamp on the point count.
- HDR0, 8'hA5, first frame byte.
- HDR1, 8'h5A, second frame byte.
- CMD_ID, 8'h0C, command byte identifying a calibration frame.

Ports:
- i_clk_50m  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_calib_make  in  1  one-cycle pulse: a bank has been completed
- i_calib_pingpang  in  1  current write bank; already toggled in the cycle i_calib_make is high
- i_calib_points  in  16  number of points in the completed bank
- o_calib_rdbank  out  1  bank select to the buffer RAM
- o_calib_rdaddr  out  10  byte address to the buffer RAM
- i_calib_rddata  in  8  RAM read data, valid RD_LAT clocks after the address
- o_tx_valid  out  1  stream byte valid
- o_tx_data  out  8  stream byte
- o_tx_sof  out  1  high with the first byte of a frame
- o_tx_eof  out  1  high with the last byte of a frame
- i_tx_ready  in  1  sink accepts the byte when o_tx_valid and i_tx_ready are both high
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse after the last byte is accepted
- o_drop_cnt  out  8  count of make pulses dropped while busy; saturates at 255

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset is asynchronous and may assert mid-frame. The frame is abandoned and o_tx_valid drops immediately.
- On i_calib_make in IDLE:
  - latch bank = ~i_calib_pingpang;
  - latch N = min(i_calib_points, MAX_POINTS);
  - clear the checksum; o_busy rises the next cycle.
- i_calib_make while busy: the pulse is ignored and o_drop_cnt increments (saturating). The frame in progress is unaffected.
- States:
  - IDLE
  - HDR: bytes HDR0, HDR1, CMD_ID, N[15:8], N[7:0], one per accepted handshake.
  - RD_ISSUE: drive rdaddr = byte index.
  - RD_WAIT: count RD_LAT clocks, then capture i_calib_rddata into the output register.
  - DATA: hold o_tx_valid until accepted. If more bytes remain, go to RD_ISSUE with index+1; otherwise go to CSUM.
  - CSUM: present the checksum byte with o_tx_eof.
  - DONE: pulse o_frame_done, then IDLE.
- HDR with N = 0 goes directly to CSUM.
- Payload length is 8*N bytes, addresses 0..8N-1; with N = 128 the last address is 1023.
- Frame length is 6 + 8N bytes.
- Checksum: XOR of every byte from CMD_ID through the last payload byte. HDR0 and HDR1 are excluded.
- o_tx_data and o_tx_valid are registered. Data and sof/eof must not change while valid is high and ready is low.
- o_tx_sof is high only with HDR0. o_tx_eof is high only with the checksum byte.
- o_calib_rdbank is held at the latched bank for the whole frame.
- o_calib_rdaddr holds its last value when not reading.
- Throughput: at most one payload byte per (RD_LAT+2) clocks; header and checksum bytes one per clock with ready high.
- First-byte latency: o_tx_valid with HDR0 appears 1 clock after the i_calib_make cycle.

Optional Feature:
- CALIB_CRC16_EN defined:
  - Trailer is 2 bytes of CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no final XOR).
  - CRC covers CMD_ID through the last payload byte; high byte first, o_tx_eof on the low byte.
  - Frame length is 7 + 8N bytes.
- CALIB_CRC16_EN undefined: 1-byte XOR checksum as specified above.

Test Plan:
- N=1, pingpang=1 at make, RAM bank0 bytes 11..18, ready always 1.
  - Required: rdbank=0, stream A5 5A 0C 00 01 11 12 13 14 15 16 17 18, checksum 0C^01^11^..^18.
  - Required: sof on A5, eof on the checksum byte, o_frame_done 1 clock after it.
- N=0 → 6 bytes A5 5A 0C 00 00 0C; no RAM reads.
- points=300, payload byte = address[7:0] → clamp to 128:
  - count bytes 00 80; 1030 bytes total; last rdaddr = 1023.
- Ready toggled pseudo-randomly (50%) with N=4:
  - byte sequence identical to the ready=1 run;
  - data, sof and eof stable while stalled.
- Second make at the 10th byte of a frame → o_drop_cnt=1, the frame completes unchanged; 300 makes while busy → o_drop_cnt=255.
- Reset asserted during payload byte 3 → valid=0 and busy=0 at once; the next make starts a clean frame with sof on A5.
